// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Feature macro: ID_EX_LOAD_USE_STALL_EN enables the load-use interlock.
//
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   id_valid           decode slot holds a real instruction
//   id_pc, id_inst     decode PC and instruction word
//   id_ex/id_m/id_wb   decoder control bundles
//   id_rs1_data,
//   id_rs2_data,
//   id_imm             register operands and immediate
//   flush              taken branch/jump in EX, kill decode slot
//   hold               memory stall, freeze this register
//   ex_*               registered bundle presented to EX
//   ex_rd/rs1/rs2      register fields of the EX instruction
//   stall              combinational, holds PC and IF/ID

package id_ex_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  c_ex;
    logic [2:0]  c_m;
    logic [2:0]  c_wb;
  } id_ex_t;

endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_inst,
  input  logic [4:0]      id_ex,
  input  logic [2:0]      id_m,
  input  logic [2:0]      id_wb,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush,
  input  logic            hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_inst,
  output logic [4:0]      ex_ctrl_ex,
  output logic [2:0]      ex_ctrl_m,
  output logic [2:0]      ex_ctrl_wb,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            stall
);

  id_ex_t          ctl_q, ctl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1d_q, rs1d_d;
  logic [XLEN-1:0] rs2d_q, rs2d_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic load_use;
  logic sel_hold;
  logic sel_bub;
  logic sel_cap;

`ifdef ID_EX_LOAD_USE_STALL_EN
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_load;
  logic       rd_hit;

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  // Both source fields are compared for every opcode;
  // U/J formats may stall needlessly, which is harmless.
  assign ex_load = ctl_q.valid
                 & (ctl_q.c_wb[1:0] == 2'b11);
  assign rd_hit  = (ex_rd != 5'd0)
                 & ((ex_rd == id_rs1)
                  | (ex_rd == id_rs2));
  assign load_use = ex_load & rd_hit & id_valid;
`else
  assign load_use = 1'b0;
`endif

  assign stall = load_use & ~flush & ~hold;

  // One-hot action select: hold beats flush beats load-use.
  always_comb begin
    sel_hold = hold;
    sel_bub  = ~hold & (flush | load_use);
    sel_cap  = ~hold & ~flush & ~load_use;
  end

  always_comb begin
    ctl_d  = ctl_q;
    pc_d   = pc_q;
    rs1d_d = rs1d_q;
    rs2d_d = rs2d_q;
    imm_d  = imm_q;
    unique case (1'b1)
      sel_hold: begin
      end
      sel_bub: begin
        // Datapath regs keep stale values; only
        // control and valid must be cleared.
        ctl_d.valid = 1'b0;
        ctl_d.inst  = NOP;
        ctl_d.c_ex  = '0;
        ctl_d.c_m   = '0;
        ctl_d.c_wb  = '0;
      end
      sel_cap: begin
        ctl_d.valid = id_valid;
        ctl_d.inst  = id_inst;
        // A void slot must never write or branch.
        ctl_d.c_ex  = id_valid ? id_ex : 5'd0;
        ctl_d.c_m   = id_valid ? id_m  : 3'd0;
        ctl_d.c_wb  = id_valid ? id_wb : 3'd0;
        pc_d        = id_pc;
        rs1d_d      = id_rs1_data;
        rs2d_d      = id_rs2_data;
        imm_d       = id_imm;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q  <= '0;
      pc_q   <= '0;
      rs1d_q <= '0;
      rs2d_q <= '0;
      imm_q  <= '0;
    end else begin
      ctl_q  <= ctl_d;
      pc_q   <= pc_d;
      rs1d_q <= rs1d_d;
      rs2d_q <= rs2d_d;
      imm_q  <= imm_d;
    end
  end

  assign ex_valid    = ctl_q.valid;
  assign ex_inst     = ctl_q.inst;
  assign ex_ctrl_ex  = ctl_q.c_ex;
  assign ex_ctrl_m   = ctl_q.c_m;
  assign ex_ctrl_wb  = ctl_q.c_wb;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1d_q;
  assign ex_rs2_data = rs2d_q;
  assign ex_imm      = imm_q;
  assign ex_rd       = ctl_q.inst[11:7];
  assign ex_rs1      = ctl_q.inst[19:15];
  assign ex_rs2      = ctl_q.inst[24:20];

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// Table vectors plus load-use / flush / hold / reset sequences.

module tb_id_ex_stage;

  localparam int XLEN = 64;

`ifdef ID_EX_LOAD_USE_STALL_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  localparam int K_CAP  = 0;
  localparam int K_BUB  = 1;
  localparam int K_KEEP = 2;
  localparam int K_ZERO = 3;

  localparam logic [31:0] ADDI5 = 32'h0030_8293;
  localparam logic [31:0] SW2   = 32'h0020_A023;
  localparam logic [31:0] LW6   = 32'h0000_A303;
  localparam logic [31:0] LW0   = 32'h0000_A003;
  localparam logic [31:0] ADD62 = 32'h0023_03B3;
  localparam logic [31:0] ADD26 = 32'h0061_03B3;
  localparam logic [31:0] ADD00 = 32'h0000_03B3;
  localparam logic [31:0] BEQ   = 32'h0020_8063;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic [4:0]      id_ex;
  logic [2:0]      id_m;
  logic [2:0]      id_wb;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            flush;
  logic            hold;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_inst;
  logic [4:0]      ex_ctrl_ex;
  logic [2:0]      ex_ctrl_m;
  logic [2:0]      ex_ctrl_wb;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic            stall;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_ex       (id_ex),
    .id_m        (id_m),
    .id_wb       (id_wb),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .flush       (flush),
    .hold        (hold),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_inst     (ex_inst),
    .ex_ctrl_ex  (ex_ctrl_ex),
    .ex_ctrl_m   (ex_ctrl_m),
    .ex_ctrl_wb  (ex_ctrl_wb),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_imm      (ex_imm),
    .ex_rd       (ex_rd),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic        flush;
    logic        hold;
    logic [31:0] inst;
    logic [4:0]  cex;
    logic [2:0]  cm;
    logic [2:0]  cwb;
    logic [63:0] imm;
    logic        chk_stall;
    logic        exp_stall;
    int          kind;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  cex;
    logic [2:0]  cm;
    logic [2:0]  cwb;
    logic [63:0] pc;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] imm;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  function automatic logic [63:0] pcf(input logic [63:0] i);
    return i ^ 64'hA5A5_0000_0000_1000;
  endfunction

  function automatic logic [63:0] r1f(input logic [63:0] i);
    return i + 64'h1111;
  endfunction

  function automatic logic [63:0] r2f(input logic [63:0] i);
    return ~i;
  endfunction

  function automatic vec_t mk(
    input logic        r,
    input logic        vl,
    input logic        fl,
    input logic        hd,
    input logic [31:0] in,
    input logic [4:0]  ce,
    input logic [2:0]  cm,
    input logic [2:0]  cw,
    input logic [63:0] im,
    input logic        cs,
    input logic        es,
    input int          k
  );
    vec_t v;
    v.rst = r;  v.vld = vl; v.flush = fl; v.hold = hd;
    v.inst = in; v.cex = ce; v.cm = cm; v.cwb = cw;
    v.imm = im; v.chk_stall = cs; v.exp_stall = es;
    v.kind = k;
    return v;
  endfunction

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e = '{default: '0};
    case (v.kind)
      K_CAP: begin
        e.valid = v.vld;
        e.inst  = v.inst;
        e.cex   = v.vld ? v.cex : 5'd0;
        e.cm    = v.vld ? v.cm  : 3'd0;
        e.cwb   = v.vld ? v.cwb : 3'd0;
        e.pc    = pcf(v.imm);
        e.r1    = r1f(v.imm);
        e.r2    = r2f(v.imm);
        e.imm   = v.imm;
        e.chk   = 1'b1;
      end
      K_BUB: begin
        e.inst = 32'h0000_0013;
        e.chk  = 1'b0;
      end
      K_KEEP: e = last;
      default: e.chk = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_cmp++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst         = v.rst;
    id_valid    = v.vld;
    flush       = v.flush;
    hold        = v.hold;
    id_inst     = v.inst;
    id_ex       = v.cex;
    id_m        = v.cm;
    id_wb       = v.cwb;
    id_imm      = v.imm;
    id_pc       = pcf(v.imm);
    id_rs1_data = r1f(v.imm);
    id_rs2_data = r2f(v.imm);
    #1;
    if (v.chk_stall) chk({nm, ".stall"}, stall, v.exp_stall);
    e = expect_of(v);
    last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_vec++;
    g = sb.pop_front();
    chk({nm, ".valid"}, ex_valid, g.valid);
    chk({nm, ".inst"}, ex_inst, g.inst);
    chk({nm, ".c_ex"}, ex_ctrl_ex, g.cex);
    chk({nm, ".c_m"}, ex_ctrl_m, g.cm);
    chk({nm, ".c_wb"}, ex_ctrl_wb, g.cwb);
    if (g.chk) begin
      chk({nm, ".rd"}, ex_rd, g.inst[11:7]);
      chk({nm, ".rs1"}, ex_rs1, g.inst[19:15]);
      chk({nm, ".rs2"}, ex_rs2, g.inst[24:20]);
      chk({nm, ".pc"}, ex_pc, g.pc);
      chk({nm, ".r1d"}, ex_rs1_data, g.r1);
      chk({nm, ".r2d"}, ex_rs2_data, g.r2);
      chk({nm, ".imm"}, ex_imm, g.imm);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    hold = 1'b0; id_inst = '0; id_ex = '0;
    id_m = '0; id_wb = '0; id_imm = '0;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
    last = '{default: '0};

    for (int i = 0; i < 2; i++) begin
      v = mk(1'b1, 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, 5'($urandom),
             3'($urandom), 3'($urandom),
             {$urandom, $urandom}, i > 0, 1'b0, K_ZERO);
      apply(v, $sformatf("reset%0d", i));
    end

    tbl.push_back(mk(0,1,0,0, ADDI5, 5'b10000, 3'b000,
                     3'b100, 64'd3, 1,0, K_CAP));
    tbl.push_back(mk(0,1,0,0, SW2, 5'b10000, 3'b001,
                     3'b000, 64'd0, 1,0, K_CAP));
    tbl.push_back(mk(0,0,0,0, ADDI5, 5'b10000, 3'b000,
                     3'b100, 64'h77, 1,0, K_CAP));
    tbl.push_back(mk(0,1,1,0, ADDI5, 5'b10000, 3'b000,
                     3'b100, 64'd7, 1,0, K_BUB));
    tbl.push_back(mk(0,1,0,0, LW0, 5'b10000, 3'b000,
                     3'b111, 64'd0, 1,0, K_CAP));
    tbl.push_back(mk(0,1,0,0, ADD00, 5'b00000, 3'b000,
                     3'b100, 64'd0, 1,0, K_CAP));
    tbl.push_back(mk(0,1,0,0, BEQ, 5'b00001, 3'b110,
                     3'b000, 64'hFFFF_FFFF_FFFF_FFF0,
                     1,0, K_CAP));
    tbl.push_back(mk(0,1,0,0, ADDI5, 5'b10000, 3'b000,
                     3'b100, 64'd9, 1,0, K_CAP));
    tbl.push_back(mk(0,1,0,1, ADD62, 5'b00000, 3'b000,
                     3'b100, 64'h100, 1,0, K_KEEP));
    tbl.push_back(mk(0,0,1,1, SW2, 5'b10000, 3'b001,
                     3'b000, 64'h200, 1,0, K_KEEP));
    tbl.push_back(mk(0,1,0,1, LW6, 5'b10000, 3'b000,
                     3'b111, 64'h300, 1,0, K_KEEP));
    tbl.push_back(mk(0,1,1,0, ADDI5, 5'b10000, 3'b000,
                     3'b100, 64'h44, 1,0, K_BUB));
    tbl.push_back(mk(0,1,0,0, SW2, 5'b10000, 3'b001,
                     3'b000, 64'h55, 1,0, K_CAP));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // load-use on rs1, then the held ADD retried
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h20, 1,0, K_CAP), "lu_load");
    apply(mk(0,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h0, 1, LU, LU ? K_BUB : K_CAP), "lu_use");
    apply(mk(0,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h0, 1,0, K_CAP), "lu_retry");

    // load-use on rs2
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h24, 1,0, K_CAP), "lu2_load");
    apply(mk(0,1,0,0, ADD26, 5'b00000, 3'b000, 3'b100,
             64'h1, 1, LU, LU ? K_BUB : K_CAP), "lu2_use");
    apply(mk(0,1,0,0, ADD26, 5'b00000, 3'b000, 3'b100,
             64'h1, 1,0, K_CAP), "lu2_retry");

    // flush beats hazard
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h28, 1,0, K_CAP), "fl_load");
    apply(mk(0,1,1,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h2, 1,0, K_BUB), "fl_use");

    // hold beats hazard, hazard fires after release
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h2C, 1,0, K_CAP), "hd_load");
    apply(mk(0,1,0,1, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h3, 1,0, K_KEEP), "hd_use");
    apply(mk(0,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h3, 1, LU, LU ? K_BUB : K_CAP), "hd_rel");
    apply(mk(0,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h3, 1,0, K_CAP), "hd_retry");

    // reset during a stall
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h30, 1,0, K_CAP), "rs_load");
    apply(mk(1,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h4, 1, LU, K_ZERO), "rs_use");
    apply(mk(0,1,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h4, 1,0, K_CAP), "rs_after");

    // void decode slot behind a load never stalls
    apply(mk(0,1,0,0, LW6, 5'b10000, 3'b000, 3'b111,
             64'h34, 1,0, K_CAP), "vd_load");
    apply(mk(0,0,0,0, ADD62, 5'b00000, 3'b000, 3'b100,
             64'h5, 1,0, K_CAP), "vd_use");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
